// File: rtl/pci_arbiter.sv
// ---------------------------------------------------------------------------
// pci_arbiter
//
// Central round-robin bus arbiter for a shared PCI segment. It accepts
// active-low requests from NREQ initiators and drives at most one active-low
// grant at a time. FRAME/IRDY are watched to follow bus ownership. A grant
// that is not used within TIMEOUT cycles is withdrawn.
//
// Optional feature (compile-time macro): PCI_ARB_PARK_EN
//   When defined, an idle bus with no requests is parked on the last owner.
//   When undefined, all grants are high while idle and FRAME activity seen
//   while idle is ignored.
//
// Parameters:
//   NREQ     number of initiators (2..8)
//   TIMEOUT  cycles a granted master has to assert FRAME
//
// Ports:
//   CLK       clock, all logic on the rising edge
//   RST       synchronous reset, active-low
//   REQ       per-initiator request, active-low
//   FRAME     PCI FRAME, active-low
//   IRDY      PCI IRDY, active-low
//   GNT       per-initiator grant, active-low, registered, at most one low
//   OWNER     index of the current or most recent grantee, registered
//   BUS_BUSY  high while a transaction granted here is in progress
// ---------------------------------------------------------------------------
module pci_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NREQ-1:0]         REQ,
    input  logic                    FRAME,
    input  logic                    IRDY,
    output logic [NREQ-1:0]         GNT,
    output logic [$clog2(NREQ)-1:0] OWNER,
    output logic                    BUS_BUSY
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

    // GAP is the one-cycle all-high gap used when leaving a parked grant
    // for a different master; it is unreachable without parking.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BUSY  = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t          state, state_n;
    logic [PW-1:0]   ptr, ptr_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [NREQ-1:0] gnt_n;
    logic [PW-1:0]   owner_n;
    logic [PW-1:0]   winner;
    logic            any_req;

    // Round-robin pick: offsets are scanned from farthest to nearest so the
    // nearest requester after 'last' overwrites everything else. Offset NREQ
    // is 'last' itself, which therefore has the lowest priority.
    function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] req,
                                              input logic [PW-1:0]   last);
        logic [PW-1:0] pick;
        logic [PW-1:0] idx;
        pick = last;
        for (int i = NREQ; i >= 1; i--) begin
            idx = PW'((int'(last) + i) % NREQ);
            if (!req[idx]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

    assign any_req  = ~&REQ;
    assign winner   = rr_pick(REQ, ptr);
    assign BUS_BUSY = (state == BUSY);

    // Next-state and next-output logic. Every grant decision loads the
    // pointer and owner together and clears the timeout counter.
    always_comb begin
        state_n = state;
        gnt_n   = GNT;
        owner_n = OWNER;
        ptr_n   = ptr;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
`ifdef PCI_ARB_PARK_EN
                if (!FRAME) begin
                    // Parked master started a transaction on its own.
                    state_n = BUSY;
                    gnt_n   = '1;
                end else if (any_req) begin
                    if (!GNT[OWNER] && (winner != OWNER)) begin
                        // Take the park grant away before handing over.
                        state_n = GAP;
                        gnt_n   = '1;
                    end else begin
                        state_n = GRANT;
                        gnt_n   = ~(ONE << winner);
                        owner_n = winner;
                        ptr_n   = winner;
                        cnt_n   = '0;
                    end
                end else begin
                    gnt_n = ~(ONE << OWNER);
                end
`else
                if (any_req) begin
                    state_n = GRANT;
                    gnt_n   = ~(ONE << winner);
                    owner_n = winner;
                    ptr_n   = winner;
                    cnt_n   = '0;
                end else begin
                    gnt_n = '1;
                end
`endif
            end
            GRANT: begin
                // FRAME has priority over a simultaneous request drop.
                if (!FRAME) begin
                    state_n = BUSY;
                    gnt_n   = '1;
                end else if (REQ[OWNER]) begin
                    state_n = IDLE;
                    gnt_n   = '1;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    state_n = IDLE;
                    gnt_n   = '1;
                end else if (cnt != {CW{1'b1}}) begin
                    cnt_n = cnt + 1'b1;
                end
            end
            BUSY: begin
                if (FRAME && IRDY) begin
                    state_n = IDLE;
                end
            end
            GAP: begin
                if (any_req) begin
                    state_n = GRANT;
                    gnt_n   = ~(ONE << winner);
                    owner_n = winner;
                    ptr_n   = winner;
                    cnt_n   = '0;
                end else begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '1;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= IDLE;
            ptr   <= PW'(NREQ - 1);
            cnt   <= '0;
            GNT   <= '1;
            OWNER <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            cnt   <= cnt_n;
            GNT   <= gnt_n;
            OWNER <= owner_n;
        end
    end

endmodule

// File: tb/tb_pci_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pci_arbiter
//
// Directed self-checking bench for pci_arbiter (NREQ=4, TIMEOUT=16).
// Inputs change 1 time unit after a rising edge; outputs are checked at the
// same point, after the registers have settled. Builds with or without
// PCI_ARB_PARK_EN; the idle-grant expectations follow the macro.
// ---------------------------------------------------------------------------
module tb_pci_arbiter;

    logic       CLK;
    logic       RST;
    logic [3:0] REQ;
    logic       FRAME;
    logic       IRDY;
    logic [3:0] GNT;
    logic [1:0] OWNER;
    logic       BUS_BUSY;

    int checks;
    int failures;
    int low_cycles;

    logic [3:0] one_hot;
    logic [1:0] m;

    pci_arbiter #(
        .NREQ    (4),
        .TIMEOUT (16)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .REQ      (REQ),
        .FRAME    (FRAME),
        .IRDY     (IRDY),
        .GNT      (GNT),
        .OWNER    (OWNER),
        .BUS_BUSY (BUS_BUSY)
    );

    // Free-running clock, period 10.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Global time limit so a broken design cannot hang the run.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    // Advance to 1 unit after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic rst, input logic [3:0] req,
                                 input logic frame, input logic irdy);
        RST   = rst;
        REQ   = req;
        FRAME = frame;
        IRDY  = irdy;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] exp_gnt,
                               input logic [1:0] exp_owner, input logic exp_busy);
        checks++;
        assert ({GNT, OWNER, BUS_BUSY} === {exp_gnt, exp_owner, exp_busy})
        else begin
            failures++;
            $error("[TB] FAIL %s observed GNT=%b OWNER=%0d BUS_BUSY=%b expected GNT=%b OWNER=%0d BUS_BUSY=%b",
                   tag, GNT, OWNER, BUS_BUSY, exp_gnt, exp_owner, exp_busy);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        // Reset state.
        applyStimulus(1'b0, 4'b1111, 1'b1, 1'b1);
        tick();
        tick();
        checkOutput("reset", 4'b1111, 2'd0, 1'b0);

        // Single transaction by master 0.
        applyStimulus(1'b1, 4'b1110, 1'b1, 1'b1);
        tick();
        checkOutput("grant0_latency", 4'b1110, 2'd0, 1'b0);
        applyStimulus(1'b1, 4'b1110, 1'b0, 1'b1);
        tick();
        checkOutput("frame_release", 4'b1111, 2'd0, 1'b1);
        applyStimulus(1'b1, 4'b1111, 1'b1, 1'b0);
        tick();
        checkOutput("busy_data_phase", 4'b1111, 2'd0, 1'b1);
        applyStimulus(1'b1, 4'b1111, 1'b1, 1'b1);
        tick();
        checkOutput("bus_idle", 4'b1111, 2'd0, 1'b0);

        // Round robin from reset with all masters requesting.
        applyStimulus(1'b0, 4'b1111, 1'b1, 1'b1);
        tick();
        for (int k = 0; k < 5; k++) begin
            m       = 2'(k % 4);
            one_hot = 4'b0001 << m;
            applyStimulus(1'b1, 4'b0000, 1'b1, 1'b1);
            tick();
            checkOutput("rr_grant", ~one_hot, m, 1'b0);
            applyStimulus(1'b1, 4'b0000, 1'b0, 1'b1);
            tick();
            checkOutput("rr_busy", 4'b1111, m, 1'b1);
            applyStimulus(1'b1, 4'b0000, 1'b1, 1'b0);
            tick();
            checkOutput("rr_last_phase", 4'b1111, m, 1'b1);
            applyStimulus(1'b1, 4'b0000, 1'b1, 1'b1);
            tick();
            checkOutput("rr_gap", 4'b1111, m, 1'b0);
        end

        // Unused grant to master 2 times out after exactly 16 cycles.
        applyStimulus(1'b0, 4'b1111, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b1, 4'b1011, 1'b1, 1'b1);
        tick();
        checkOutput("timeout_grant2", 4'b1011, 2'd2, 1'b0);
        low_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            if (GNT[2] !== 1'b0) break;
            low_cycles++;
            tick();
        end
        checks++;
        assert (low_cycles === 16)
        else begin
            failures++;
            $error("[TB] FAIL timeout_length observed=%0d expected=%0d", low_cycles, 16);
        end
        checkOutput("timeout_withdrawn", 4'b1111, 2'd2, 1'b0);

        // Master 3 is served before master 2 after the timeout.
        applyStimulus(1'b1, 4'b0011, 1'b1, 1'b1);
        tick();
        checkOutput("after_timeout_m3", 4'b0111, 2'd3, 1'b0);

        // Owner drops REQ on the same edge FRAME asserts: BUSY wins.
        applyStimulus(1'b1, 4'b1011, 1'b0, 1'b1);
        tick();
        checkOutput("frame_beats_req_drop", 4'b1111, 2'd3, 1'b1);

        // Reset in the middle of a transaction.
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1);
        tick();
        checkOutput("reset_in_busy", 4'b1111, 2'd0, 1'b0);
        applyStimulus(1'b1, 4'b0000, 1'b1, 1'b1);
        tick();
        checkOutput("first_after_reset", 4'b1110, 2'd0, 1'b0);

        // Owner withdraws its request before FRAME.
        applyStimulus(1'b1, 4'b1111, 1'b1, 1'b1);
        tick();
        checkOutput("owner_req_drop", 4'b1111, 2'd0, 1'b0);
        tick();
`ifdef PCI_ARB_PARK_EN
        checkOutput("idle_parked", 4'b1110, 2'd0, 1'b0);

        // Park on master 1, then hand over to master 0 with one gap cycle.
        applyStimulus(1'b0, 4'b1111, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b1, 4'b1101, 1'b1, 1'b1);
        tick();
        checkOutput("park_grant1", 4'b1101, 2'd1, 1'b0);
        applyStimulus(1'b1, 4'b1111, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 4'b1111, 1'b1, 1'b1);
        tick();
        tick();
        checkOutput("park_on_1", 4'b1101, 2'd1, 1'b0);
        applyStimulus(1'b1, 4'b1110, 1'b1, 1'b1);
        tick();
        checkOutput("park_gap", 4'b1111, 2'd1, 1'b0);
        tick();
        checkOutput("park_handover0", 4'b1110, 2'd0, 1'b0);
`else
        checkOutput("idle_no_park", 4'b1111, 2'd0, 1'b0);

        // FRAME activity while idle is not ours and is ignored.
        applyStimulus(1'b1, 4'b1111, 1'b0, 1'b0);
        tick();
        checkOutput("idle_frame_ignored", 4'b1111, 2'd0, 1'b0);
        applyStimulus(1'b1, 4'b1111, 1'b1, 1'b1);
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
